register_file_mp: RTL



---
 rtl/register_file_mp.sv | 116 +++++++++++
 1 files changed

// File: rtl/register_file_mp.sv
// Multi-read-port flip-flop register file with byte-lane writes, optional zero
// word and write bypass, plus a sequential bulk-clear engine.
module register_file_mp #(
  parameter int unsigned AddrWidth    = 4,
  parameter int unsigned DataWidth    = 16,
  parameter int unsigned NumReadPorts = 2,
  parameter bit          ZeroReg      = 1'b1,
  parameter bit          BypassEn     = 1'b0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumReadPorts*AddrWidth-1:0] raddr_i,
  output logic [NumReadPorts*DataWidth-1:0] rdata_o,
  input  logic                              we_i,
  input  logic [AddrWidth-1:0]              waddr_i,
  input  logic [DataWidth-1:0]              wdata_i,
  input  logic [DataWidth/8-1:0]            wbe_i,
  input  logic                              clear_i,
  output logic                              busy_o,
  output logic                              wr_drop_o
);

  localparam int unsigned NumWords = 2 ** AddrWidth;
  localparam int unsigned NumBytes = DataWidth / 8;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic                 drop_q, drop_d;
  logic [DataWidth-1:0] mem_q [NumWords];
  logic [DataWidth-1:0] mem_d [NumWords];

  logic                 wr_acc;
  logic [DataWidth-1:0] wmask;
  logic [DataWidth-1:0] wr_merged;

  always_comb begin
    wmask = '0;
    for (int unsigned b = 0; b < NumBytes; b++) begin
      wmask[b*8 +: 8] = {8{wbe_i[b]}};
    end
  end

  // Stored word at the write address with the enabled lanes replaced; shared by
  // the write path and the read bypass.
  assign wr_merged = (mem_q[waddr_i] & ~wmask) | (wdata_i & wmask);
  assign wr_acc    = (state_q == IDLE) && we_i && !clear_i;
  assign drop_d    = we_i && ((state_q == CLEAR) || clear_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (wr_acc && !(ZeroReg && (waddr_i == '0))) begin
          mem_d[waddr_i] = wr_merged;
        end
      end
      CLEAR: begin
        mem_d[cnt_q] = '0;
        cnt_d        = cnt_q + AddrWidth'(1);
        if (cnt_q == '1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      for (int unsigned i = 0; i < NumWords; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      mem_q   <= mem_d;
    end
  end

  for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] word;

    assign addr = raddr_i[p*AddrWidth +: AddrWidth];

    always_comb begin
      word = mem_q[addr];
      if (BypassEn && wr_acc && (addr == waddr_i)) begin
        word = wr_merged;
      end
      if (ZeroReg && (addr == '0)) begin
        word = '0;
      end
    end

    assign rdata_o[p*DataWidth +: DataWidth] = word;
  end

  assign busy_o    = (state_q == CLEAR);
  assign wr_drop_o = drop_q;

endmodule
